move_input_ctrl: RTL and testbench

- Conditions the raw player move button before it reaches the vertical scroll stages and the collision/score top level.
- Synchronises and debounces the button, then turns presses and holds into move requests, with auto-repeat while the button is held.
- Queues the requests and releases at most one single-cycle move_pulse per video frame, so obstacle scrolling never tears mid-frame.
- Its move_pulse output replaces the raw button at every scroll_v move_btn input.

---
 rtl/move_input_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_move_input_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_input_ctrl.sv
// Player move-button conditioning: synchronise, debounce, press/auto-repeat FSM,
// and a small request queue that releases at most one move_pulse per frame.
module move_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES     = 250000,
  parameter int unsigned REPEAT_DELAY_FRAMES = 30,
  parameter int unsigned REPEAT_RATE_FRAMES  = 8,
  parameter int unsigned MAX_PENDING         = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       move_btn_raw,
  input  logic       frame_tick,
  input  logic       enable,
  output logic       move_pulse,
  output logic       btn_db,
  output logic [1:0] pending_cnt
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      DELAY_F   = 8'(REPEAT_DELAY_FRAMES);
  localparam logic [7:0]      RATE_F    = 8'(REPEAT_RATE_FRAMES);
  localparam logic            REPEAT_ON = (REPEAT_DELAY_FRAMES != 0);
  localparam logic [1:0]      PEND_MAX  = 2'(MAX_PENDING);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_REPEAT  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  logic            sync_meta_q;
  logic            sync_q;
  logic [DB_W-1:0] db_cnt_q;
  logic [DB_W-1:0] db_cnt_d;
  logic            btn_db_q;
  logic            btn_db_d;
  logic            db_rise_s;
  state_e          state_q;
  logic [7:0]      frame_cnt_q;
  logic [7:0]      frame_inc_s;
  logic            req_q;
  logic [1:0]      pend_q;
  logic [1:0]      pend_d;
  logic            pulse_q;
  logic            pulse_d;
  logic            issue_s;

  // Two-flop synchroniser; only the second stage is ever observed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      sync_meta_q <= move_btn_raw;
      sync_q      <= sync_meta_q;
    end
  end

  // Debounce: the level must disagree for DEBOUNCE_CYCLES consecutive cycles to flip.
  always_comb begin
    db_cnt_d  = db_cnt_q;
    btn_db_d  = btn_db_q;
    db_rise_s = 1'b0;
    if (sync_q == btn_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_cnt_d  = '0;
      btn_db_d  = sync_q;
      db_rise_s = sync_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  assign frame_inc_s = frame_cnt_q + 8'd1;

  // Press/auto-repeat FSM; req_q is a one-cycle registered request into the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= 8'd0;
      req_q       <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (db_rise_s) begin
            if (enable) begin
              req_q       <= 1'b1;
              frame_cnt_q <= 8'd0;
              state_q     <= ST_DELAY;
            end else begin
              state_q <= ST_LOCKOUT;
            end
          end
        end
        ST_DELAY: begin
          if (!btn_db_q) begin
            state_q <= ST_IDLE;
          end else if (!enable) begin
            state_q <= ST_LOCKOUT;
          end else if (frame_tick && REPEAT_ON) begin
            if (frame_inc_s == DELAY_F) begin
              req_q       <= 1'b1;
              frame_cnt_q <= 8'd0;
              state_q     <= ST_REPEAT;
            end else begin
              frame_cnt_q <= frame_inc_s;
            end
          end
        end
        ST_REPEAT: begin
          if (!btn_db_q) begin
            state_q <= ST_IDLE;
          end else if (!enable) begin
            state_q <= ST_LOCKOUT;
          end else if (frame_tick) begin
            if (frame_inc_s == RATE_F) begin
              req_q       <= 1'b1;
              frame_cnt_q <= 8'd0;
            end else begin
              frame_cnt_q <= frame_inc_s;
            end
          end
        end
        ST_LOCKOUT: begin
          // A hold that survived a restart must be released before it can move again.
          if (!btn_db_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          frame_cnt_q <= 8'd0;
        end
      endcase
    end
  end

  assign issue_s = frame_tick & enable & (pend_q != 2'd0);

  // Saturating request queue; a request and an issue in the same cycle cancel out.
  always_comb begin
    pend_d  = pend_q;
    pulse_d = 1'b0;
    if (!enable) begin
      pend_d  = 2'd0;
      pulse_d = 1'b0;
    end else begin
      pulse_d = issue_s;
      if (req_q && !issue_s) begin
        if (pend_q != PEND_MAX) begin
          pend_d = pend_q + 2'd1;
        end else begin
          pend_d = pend_q;
        end
      end else if (!req_q && issue_s) begin
        pend_d = pend_q - 2'd1;
      end else begin
        pend_d = pend_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 2'd0;
      pulse_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      pulse_q <= pulse_d;
    end
  end

  assign move_pulse  = pulse_q;
  assign btn_db      = btn_db_q;
  assign pending_cnt = pend_q;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Randomised and directed bench for move_input_ctrl, checked every cycle against
// a behavioural model of button timing, repeat schedule and request queue.
module tb_move_input_ctrl;

  localparam int DEB   = 4;
  localparam int RDLY  = 3;
  localparam int RRATE = 2;
  localparam int MAXP  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_btn_raw = 1'b0;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b1;
  logic       move_pulse;
  logic       btn_db;
  logic [1:0] pending_cnt;

  move_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY_FRAMES(RDLY),
    .REPEAT_RATE_FRAMES(RRATE),
    .MAX_PENDING(MAXP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .move_btn_raw(move_btn_raw),
    .frame_tick(frame_tick),
    .enable(enable),
    .move_pulse(move_pulse),
    .btn_db(btn_db),
    .pending_cnt(pending_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int period = 20;
  int phase = 0;
  int cyc = 0;

  // Model: raw-history pipe, run length of disagreement, hold bookkeeping, queue depth.
  bit m_s1, m_s2, m_db, m_req, m_pulse, m_hold, m_lock, m_rep;
  int m_run, m_pend, m_frames;

  int seen_pulses, max_pend;
  bit seen_db;

  task automatic model_clear();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_req = 0; m_pulse = 0;
    m_hold = 0; m_lock = 0; m_rep = 0;
    m_run = 0; m_pend = 0; m_frames = 0;
  endtask

  task automatic model_step();
    bit db_old, rise, req_now, issue;
    int thr;
    if (!rst_n) begin
      model_clear();
      return;
    end
    if (!enable) begin
      m_pend = 0;
      m_pulse = 0;
    end else begin
      issue = frame_tick && (m_pend > 0);
      m_pulse = issue;
      m_pend = m_pend - int'(issue) + int'(m_req);
      if (m_pend > MAXP) m_pend = MAXP;
    end
    db_old = m_db;
    rise = 0;
    if (m_s2 == m_db) m_run = 0;
    else if (m_run + 1 == DEB) begin
      m_db = m_s2; m_run = 0; rise = m_s2;
    end else m_run++;
    req_now = 0;
    if (!m_hold && !m_lock) begin
      if (rise) begin
        if (enable) begin
          req_now = 1; m_hold = 1; m_frames = 0; m_rep = 0;
        end else m_lock = 1;
      end
    end else if (!db_old) begin
      m_hold = 0; m_lock = 0;
    end else if (m_hold && !enable) begin
      m_hold = 0; m_lock = 1;
    end else if (m_hold && frame_tick) begin
      m_frames++;
      thr = m_rep ? RRATE : RDLY;
      if (thr != 0 && m_frames == thr) begin
        req_now = 1; m_frames = 0; m_rep = 1;
      end
    end
    m_req = req_now;
    m_s2 = m_s1;
    m_s1 = move_btn_raw;
  endtask

  task automatic check();
    vectors++;
    if (move_pulse !== m_pulse || btn_db !== m_db || pending_cnt !== m_pend[1:0]) begin
      miscompares++;
      $display("FAIL model cyc=%0d pulse/db/pend got %b/%b/%0d want %b/%b/%0d",
               cyc, move_pulse, btn_db, pending_cnt, m_pulse, m_db, m_pend);
    end
    seen_pulses += int'(move_pulse);
    if (int'(pending_cnt) > max_pend) max_pend = int'(pending_cnt);
    if (btn_db) seen_db = 1;
  endtask

  task automatic check_lit(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic clear_obs();
    seen_pulses = 0; max_pend = 0; seen_db = 0;
  endtask

  task automatic tick();
    frame_tick = (phase >= period - 1);
    @(posedge clk);
    model_step();
    phase = frame_tick ? 0 : phase + 1;
    cyc++;
    @(negedge clk);
    check();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 200 && phase != p; i++) tick();
  endtask

  initial begin
    int rise_at;
    int run_left;
    model_clear();
    clear_obs();
    #1;
    check_lit("reset_pend", int'(pending_cnt), 0);
    check_lit("reset_db", int'(btn_db), 0);
    @(negedge clk);
    run(3);
    rst_n = 1'b1;
    run(30);

    // Glitch shorter than the debounce window
    wait_phase(0);
    clear_obs();
    move_btn_raw = 1'b1; run(3);
    move_btn_raw = 1'b0; run(100);
    check_lit("glitch_db", int'(seen_db), 0);
    check_lit("glitch_pulses", seen_pulses, 0);
    check_lit("glitch_pend", max_pend, 0);

    // Single press rising 5 cycles before a frame tick
    wait_phase(14);
    clear_obs();
    rise_at = 0;
    move_btn_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (btn_db && rise_at == 0) rise_at = i;
    end
    move_btn_raw = 1'b0;
    run(60);
    check_lit("press_latency", rise_at, 6);
    check_lit("press_pend_peak", max_pend, 1);
    check_lit("press_pulses", seen_pulses, 1);
    check_lit("press_pend_end", int'(pending_cnt), 0);

    // Hold for 10 frames: initial move plus repeats at ticks 3,5,7,9
    wait_phase(0);
    clear_obs();
    move_btn_raw = 1'b1; run(200);
    move_btn_raw = 1'b0; run(80);
    check_lit("hold_pulses", seen_pulses, 5);
    check_lit("hold_pend_end", int'(pending_cnt), 0);

    // Saturation: five presses inside one long frame gap
    wait_phase(0);
    period = 100;
    clear_obs();
    for (int k = 0; k < 5; k++) begin
      move_btn_raw = 1'b1; run(6);
      move_btn_raw = 1'b0; run(6);
    end
    run(2);
    check_lit("sat_peak", max_pend, 3);
    check_lit("sat_no_early_pulse", seen_pulses, 0);
    period = 20;
    run(100);
    check_lit("sat_pulses", seen_pulses, 3);
    check_lit("sat_pend_end", int'(pending_cnt), 0);

    // Enable drop with two queued requests and the button held
    wait_phase(0);
    period = 100;
    move_btn_raw = 1'b1; run(6);
    move_btn_raw = 1'b0; run(6);
    move_btn_raw = 1'b1; run(10);
    check_lit("en_pend_before", int'(pending_cnt), 2);
    clear_obs();
    enable = 1'b0; tick();
    check_lit("en_pend_cleared", int'(pending_cnt), 0);
    run(19);
    check_lit("en_off_pulses", seen_pulses, 0);
    enable = 1'b1;
    period = 20;
    run(60);
    check_lit("en_held_pulses", seen_pulses, 0);
    check_lit("en_held_pend", max_pend, 0);
    move_btn_raw = 1'b0; run(10);
    clear_obs();
    move_btn_raw = 1'b1; run(10);
    move_btn_raw = 1'b0; run(50);
    check_lit("en_repress_pulses", seen_pulses, 1);

    // Asynchronous reset in the middle of auto-repeat
    wait_phase(0);
    move_btn_raw = 1'b1; run(100);
    #2;
    rst_n = 1'b0;
    #1;
    check_lit("areset_pulse", int'(move_pulse), 0);
    check_lit("areset_db", int'(btn_db), 0);
    check_lit("areset_pend", int'(pending_cnt), 0);
    model_clear();
    run(3);
    rst_n = 1'b1;
    clear_obs();
    run(5);
    check_lit("areset_release_db", int'(seen_db), 0);
    check_lit("areset_release_pulses", seen_pulses, 0);
    run(60);
    move_btn_raw = 1'b0; run(30);

    // Randomised soak
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        move_btn_raw = 1'($urandom_range(0, 1));
        run_left = int'($urandom_range(1, 40));
      end
      run_left--;
      if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 14) == 0) enable = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
